// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the timekeeper real-time clock core.
// Holds the alarm FSM states, the time-of-day struct and field legality helpers.
package timekeeper_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HRS_MAX = 23;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic [4:0] hrs;
    logic [5:0] min;
    logic [5:0] sec;
  } tk_time_t;

  function automatic logic time_legal(input logic [4:0] hrs,
                                      input logic [5:0] min,
                                      input logic [5:0] sec);
    return (hrs <= 5'(HRS_MAX)) && (min <= 6'(MIN_MAX)) && (sec <= 6'(SEC_MAX));
  endfunction

  // 24h hour to 12h clock face: 0 and 12 both show as 12.
  function automatic logic [4:0] hrs_12(input logic [4:0] hrs);
    if (hrs == 5'd0)
      return 5'd12;
    else if (hrs > 5'd12)
      return hrs - 5'd12;
    else
      return hrs;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load; carry flags the wrap on an
// incrementing cycle so counters can be cascaded within a single edge.
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] TOP = W'(MAX);

  assign carry = inc && (value == TOP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      value <= '0;
    else if (load)
      value <= load_val;
    else if (inc)
      value <= carry ? '0 : value + W'(1);
  end

endmodule

// File: rtl/timekeeper.sv
// 24-hour real-time clock with prescaler, synchronous load, 12-hour view and
// an alarm that rings, snoozes and times out after a minute unanswered.
module timekeeper
  import timekeeper_pkg::*;
#(
  parameter int CLK_PER_SEC = 1,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic [4:0] load_hrs,
  input  logic       mode_12h,
  input  logic       alarm_set,
  input  logic [5:0] alarm_min,
  input  logic [4:0] alarm_hrs,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  input  logic       snooze,
  output logic [5:0] count_sec,
  output logic [5:0] count_min,
  output logic [4:0] count_hrs,
  output logic [4:0] disp_hrs,
  output logic       pm,
  output logic       tick_sec,
  output logic       load_err,
  output logic       alarm_ring
);

  localparam int            PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_TC    = PW'(CLK_PER_SEC - 1);
  localparam logic [5:0]    RING_LAST = 6'(SEC_MAX);

  logic [PW-1:0] presc;
  logic          load_ok;
  logic          aset_ok;
  logic          adv;
  logic          sec_carry;
  logic          min_carry;
  logic          hrs_carry;
  logic [5:0]    sec_v;
  logic [5:0]    min_v;
  logic [4:0]    hrs_v;
  tk_time_t      nxt;
  tk_time_t      alarm_q;
  tk_time_t      snz_q;
  tk_time_t      snz_n;
  logic [6:0]    snz_sum;
  logic [4:0]    new_hrs;
  logic [4:0]    h12_q;
  logic          alarm_hit;
  logic          snz_hit;
  logic          snz_set;
  alarm_state_t  state;
  alarm_state_t  state_n;
  logic [5:0]    ring_cnt;
  logic [5:0]    ring_cnt_n;

  assign load_ok = load && time_legal(load_hrs, load_min, load_sec);
  assign aset_ok = alarm_set && time_legal(alarm_hrs, alarm_min, 6'd0);
  // A legal load takes priority over a coincident seconds advance.
  assign adv     = en && (presc == PRE_TC) && !load_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      presc <= '0;
    else if (load_ok)
      presc <= '0;
    else if (en)
      presc <= (presc == PRE_TC) ? '0 : presc + PW'(1);
  end

  mod_counter #(.MAX(SEC_MAX), .W(6)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (adv),
    .load     (load_ok),
    .load_val (load_sec),
    .value    (sec_v),
    .carry    (sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .W(6)) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (sec_carry),
    .load     (load_ok),
    .load_val (load_min),
    .value    (min_v),
    .carry    (min_carry)
  );

  mod_counter #(.MAX(HRS_MAX), .W(5)) u_hrs (
    .clk      (clk),
    .reset    (reset),
    .inc      (min_carry),
    .load     (load_ok),
    .load_val (load_hrs),
    .value    (hrs_v),
    .carry    (hrs_carry)
  );

  // Time that becomes visible if this cycle advances; alarm matching looks
  // ahead so alarm_ring rises together with the matching time.
  always_comb begin
    nxt.sec = sec_carry ? 6'd0 : sec_v + 6'd1;
    nxt.min = min_carry ? 6'd0 : (sec_carry ? min_v + 6'd1 : min_v);
    nxt.hrs = hrs_carry ? 5'd0 : (min_carry ? hrs_v + 5'd1 : hrs_v);
  end

  assign alarm_hit = adv && (nxt == alarm_q);
  assign snz_hit   = adv && (nxt == snz_q);

  always_comb begin
    if (load_ok)
      new_hrs = load_hrs;
    else if (adv)
      new_hrs = nxt.hrs;
    else
      new_hrs = hrs_v;
  end

  always_comb begin
    snz_sum   = 7'(min_v) + 7'(SNOOZE_MIN);
    snz_n.sec = 6'd0;
    if (snz_sum > 7'(MIN_MAX)) begin
      snz_n.min = 6'(snz_sum - 7'd60);
      snz_n.hrs = (hrs_v == 5'(HRS_MAX)) ? 5'd0 : hrs_v + 5'd1;
    end else begin
      snz_n.min = snz_sum[5:0];
      snz_n.hrs = hrs_v;
    end
  end

  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    snz_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (alarm_en && alarm_hit) begin
          state_n    = ST_RINGING;
          ring_cnt_n = 6'd0;
        end
      end
      ST_RINGING: begin
        if (alarm_ack || !alarm_en) begin
          state_n = ST_IDLE;
        end else if (snooze) begin
          state_n = ST_SNOOZED;
          snz_set = 1'b1;
        end else if (adv) begin
          if (ring_cnt == RING_LAST)
            state_n = ST_IDLE;
          else
            ring_cnt_n = ring_cnt + 6'd1;
        end
      end
      ST_SNOOZED: begin
        if (alarm_ack || !alarm_en || aset_ok) begin
          state_n = ST_IDLE;
        end else if (snz_hit) begin
          state_n    = ST_RINGING;
          ring_cnt_n = 6'd0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ring_cnt <= 6'd0;
    end else begin
      state    <= state_n;
      ring_cnt <= ring_cnt_n;
    end
  end

  // Alarm set wins over a coincident snooze when writing the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_q <= '0;
      snz_q   <= '0;
    end else begin
      if (aset_ok)
        alarm_q <= '{hrs: alarm_hrs, min: alarm_min, sec: 6'd0};
      if (aset_ok)
        snz_q <= '0;
      else if (snz_set)
        snz_q <= snz_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_sec   <= 1'b0;
      load_err   <= 1'b0;
      pm         <= 1'b0;
      h12_q      <= 5'd12;
      alarm_ring <= 1'b0;
    end else begin
      tick_sec   <= adv;
      load_err   <= (load && !load_ok) || (alarm_set && !aset_ok);
      pm         <= (new_hrs >= 5'd12);
      h12_q      <= hrs_12(new_hrs);
      alarm_ring <= (state_n == ST_RINGING);
    end
  end

  assign count_sec = sec_v;
  assign count_min = min_v;
  assign count_hrs = hrs_v;
  // Both hour views are registered; mode_12h only picks between them.
  assign disp_hrs  = mode_12h ? h12_q : hrs_v;

endmodule

// File: tb/tb_timekeeper.sv
// Self-checking bench for timekeeper: two instances (1 and 4 clocks per second)
// checked every cycle against a seconds-of-day model, plus directed literals.
module tb_timekeeper;

  localparam int SNZ = 5;
  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_sec = '0;
  logic [5:0] load_min = '0;
  logic [4:0] load_hrs = '0;
  logic       mode_12h = 1'b0;
  logic       alarm_set = 1'b0;
  logic [5:0] alarm_min = '0;
  logic [4:0] alarm_hrs = '0;
  logic       alarm_en = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       snooze = 1'b0;

  logic [5:0] c1_sec, c1_min, c4_sec, c4_min;
  logic [4:0] c1_hrs, c1_disp, c4_hrs, c4_disp;
  logic       c1_pm, c1_tick, c1_err, c1_ring;
  logic       c4_pm, c4_tick, c4_err, c4_ring;
  logic [25:0] out1, out4;

  int n_chk = 0;
  int n_fail = 0;
  int tick1 = 0;
  int tick4 = 0;

  always #5 clk = ~clk;

  timekeeper #(.CLK_PER_SEC(1), .SNOOZE_MIN(SNZ)) dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hrs(load_hrs),
    .mode_12h(mode_12h), .alarm_set(alarm_set), .alarm_min(alarm_min),
    .alarm_hrs(alarm_hrs), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .snooze(snooze), .count_sec(c1_sec), .count_min(c1_min), .count_hrs(c1_hrs),
    .disp_hrs(c1_disp), .pm(c1_pm), .tick_sec(c1_tick), .load_err(c1_err),
    .alarm_ring(c1_ring)
  );

  timekeeper #(.CLK_PER_SEC(4), .SNOOZE_MIN(SNZ)) dut4 (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hrs(load_hrs),
    .mode_12h(mode_12h), .alarm_set(alarm_set), .alarm_min(alarm_min),
    .alarm_hrs(alarm_hrs), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .snooze(snooze), .count_sec(c4_sec), .count_min(c4_min), .count_hrs(c4_hrs),
    .disp_hrs(c4_disp), .pm(c4_pm), .tick_sec(c4_tick), .load_err(c4_err),
    .alarm_ring(c4_ring)
  );

  assign out1 = {c1_sec, c1_min, c1_hrs, c1_disp, c1_pm, c1_tick, c1_err, c1_ring};
  assign out4 = {c4_sec, c4_min, c4_hrs, c4_disp, c4_pm, c4_tick, c4_err, c4_ring};

  // Model: time kept as seconds of day; alarm behaviour from the rules.
  typedef struct {
    int t;
    int presc;
    int st;
    int ah;
    int am;
    int tgt;
    int el;
    bit tick;
    bit err;
    bit ring;
  } mstate_t;

  mstate_t m1, m4;

  function automatic mstate_t m_reset();
    mstate_t m;
    m.t = 0; m.presc = 0; m.st = M_IDLE; m.ah = 0; m.am = 0;
    m.tgt = 0; m.el = 0; m.tick = 0; m.err = 0; m.ring = 0;
    return m;
  endfunction

  function automatic mstate_t m_step(mstate_t m, int cps);
    bit ld_ok, as_ok, moved;
    int old_t;
    ld_ok = load && (load_sec < 60) && (load_min < 60) && (load_hrs < 24);
    as_ok = alarm_set && (alarm_min < 60) && (alarm_hrs < 24);
    old_t = m.t;
    moved = 0;
    if (ld_ok) begin
      m.t = int'(load_hrs) * 3600 + int'(load_min) * 60 + int'(load_sec);
      m.presc = 0;
    end else if (en) begin
      if (m.presc == cps - 1) begin
        m.presc = 0;
        m.t = (m.t + 1) % 86400;
        moved = 1;
      end else begin
        m.presc = m.presc + 1;
      end
    end
    m.tick = moved;
    m.err = (load && !ld_ok) || (alarm_set && !as_ok);
    case (m.st)
      M_IDLE:
        if (alarm_en && moved && m.t == m.ah * 3600 + m.am * 60) begin
          m.st = M_RING; m.el = 0;
        end
      M_RING:
        if (alarm_ack || !alarm_en) m.st = M_IDLE;
        else if (snooze) begin
          m.st = M_SNZ;
          m.tgt = ((old_t / 60 + SNZ) % 1440) * 60;
        end else if (moved) begin
          m.el = m.el + 1;
          if (m.el == 60) m.st = M_IDLE;
        end
      default:
        if (alarm_ack || !alarm_en || as_ok) m.st = M_IDLE;
        else if (moved && m.t == m.tgt) begin
          m.st = M_RING; m.el = 0;
        end
    endcase
    if (as_ok) begin
      m.ah = int'(alarm_hrs); m.am = int'(alarm_min); m.tgt = 0;
    end
    m.ring = (m.st == M_RING);
    return m;
  endfunction

  function automatic logic [25:0] m_out(mstate_t m);
    int h, mi, s, d;
    h = m.t / 3600;
    mi = (m.t / 60) % 60;
    s = m.t % 60;
    d = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    return {6'(s), 6'(mi), 5'(h), 5'(d), (h >= 12), m.tick, m.err, m.ring};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1 = m_reset();
      m4 = m_reset();
    end else begin
      m1 = m_step(m1, 1);
      m4 = m_step(m4, 4);
    end
  end

  task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_dut1", out1, m_out(m1));
    chk("model_dut4", out4, m_out(m4));
    if (c1_tick) tick1++;
    if (c4_tick) tick4++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load_hrs = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_aset(input int h, input int m);
    alarm_hrs = 5'(h); alarm_min = 6'(m);
    alarm_set = 1'b1;
    cyc(1);
    alarm_set = 1'b0;
  endtask

  // which: 0 = dut4 ring high, 1 = dut4 ring low, 2 = dut4 seconds == 10.
  task automatic wait4(input int which, input int budget, output int n);
    bit hit;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      cyc(1);
      hit = (which == 0) ? c4_ring : (which == 1) ? !c4_ring : (c4_sec == 6'd10);
      if (hit) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk_int("wait_budget", n, which);
  endtask

  int n;

  initial begin
    reset = 1'b0;
    mode_12h = 1'b1;
    cyc(2);
    chk("reset_12h_dut1", out1, {6'd0, 6'd0, 5'd0, 5'd12, 4'b0000});
    chk("reset_12h_dut4", out4, {6'd0, 6'd0, 5'd0, 5'd12, 4'b0000});
    mode_12h = 1'b0;
    #1;
    chk_int("reset_24h_disp", int'(c1_disp), 0);

    reset = 1'b1;
    en = 1'b1;
    tick1 = 0;
    cyc(7200);
    en = 1'b0;
    chk("run7200_dut1", {c1_hrs, c1_min, c1_sec}, {5'd2, 6'd0, 6'd0});
    chk("run7200_dut4", {c4_hrs, c4_min, c4_sec}, {5'd0, 6'd30, 6'd0});
    cyc(1);
    chk_int("ticks7200", tick1, 7200);

    do_load(23, 59, 59);
    chk("load_235959", {c4_hrs, c4_min, c4_sec, c4_pm}, {5'd23, 6'd59, 6'd59, 1'b1});
    tick4 = 0;
    en = 1'b1;
    cyc(4);
    en = 1'b0;
    chk("wrap_dut4", {c4_hrs, c4_min, c4_sec, c4_pm}, {5'd0, 6'd0, 6'd0, 1'b0});
    chk("wrap_dut1", {c1_hrs, c1_min, c1_sec}, {5'd0, 6'd0, 6'd3});
    cyc(1);
    chk_int("wrap_ticks4", tick4, 1);

    do_load(12, 60, 0);
    chk("bad_load", {c4_hrs, c4_min, c4_sec, c4_err}, {5'd0, 6'd0, 6'd0, 1'b1});
    cyc(1);
    chk_int("bad_load_pulse", int'(c4_err), 0);
    do_aset(24, 0);
    chk_int("bad_aset", int'(c1_err), 1);

    do_load(13, 5, 0);
    mode_12h = 1'b1;
    #1;
    chk("view12", {c4_disp, c4_pm}, {5'd1, 1'b1});
    mode_12h = 1'b0;
    #1;
    chk_int("view24", int'(c4_disp), 13);

    alarm_en = 1'b1;
    do_aset(6, 30);
    do_load(6, 29, 58);
    en = 1'b1;
    wait4(0, 20, n);
    chk_int("ring_latency", n, 8);
    chk("ring_time", {c4_hrs, c4_min, c4_sec}, {5'd6, 6'd30, 6'd0});
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    chk("ack_idle", {c4_ring, c1_ring}, 26'd0);

    do_load(6, 29, 58);
    wait4(0, 20, n);
    wait4(2, 100, n);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    chk_int("snoozed", int'(c4_ring), 0);
    wait4(0, 2000, n);
    chk("rering_time", {c4_hrs, c4_min, c4_sec}, {5'd6, 6'd35, 6'd0});
    wait4(1, 400, n);
    chk("timeout_time", {c4_hrs, c4_min, c4_sec}, {5'd6, 6'd36, 6'd0});

    en = 1'b0;
    do_load(6, 30, 0);
    cyc(2);
    chk("load_no_ring", {c4_ring, c1_ring}, 26'd0);

    do_load(6, 29, 59);
    en = 1'b1;
    cyc(1);
    chk_int("ring_before_reset", int'(c1_ring), 1);
    mode_12h = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset_dut1", out1, {6'd0, 6'd0, 5'd0, 5'd12, 4'b0000});
    chk("mid_reset_dut4", out4, {6'd0, 6'd0, 5'd0, 5'd12, 4'b0000});
    cyc(2);
    reset = 1'b1;
    en = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
